// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable divider producing a tick strobe and a near-50% clk_out.
// Define CLKDIV_SYNC_EN to add the sync_in phase-restart input.
module clkdiv_prog #(
   parameter int WIDTH     = 16,
   parameter int DIV_RESET = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] div_value,
   input  logic             div_load,
   output logic             div_ack,
   output logic [WIDTH-1:0] div_active,
   output logic             tick,
   output logic             clk_out
`ifdef CLKDIV_SYNC_EN
   ,
   input  logic             sync_in
`endif
);
   logic [WIDTH-1:0] r_cnt, r_div, r_pval;
   logic             r_pend, r_tick, r_clk, r_ack;
   logic [WIDTH-1:0] w_d, w_cnt_next;
   logic [WIDTH:0]   w_h;
   logic             w_sync, w_wrap, w_apply;
`ifdef CLKDIV_SYNC_EN
   assign w_sync = sync_in;
`else
   assign w_sync = 1'b0;
`endif
   // A zero divisor behaves as divide-by-one; H is widened so all-ones cannot overflow.
   assign w_d        = (r_div == '0) ? WIDTH'(1) : r_div;
   assign w_h        = ({1'b0, w_d} + (WIDTH+1)'(1)) >> 1;
   assign w_wrap     = enable && ((r_cnt == w_d - WIDTH'(1)) || w_sync);
   assign w_cnt_next = w_wrap ? '0 : r_cnt + WIDTH'(1);
   assign w_apply    = r_pend && (w_wrap || !enable);
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_div  <= WIDTH'(DIV_RESET);
         r_pval <= '0;
         r_pend <= 1'b0;
         r_tick <= 1'b0;
         r_clk  <= 1'b0;
         r_ack  <= 1'b0;
      end else begin
         if (div_load) r_pval <= div_value;
         r_pend <= div_load || (r_pend && !w_apply);
         r_ack  <= w_apply;
         if (w_apply) begin
            r_div  <= r_pval;
            r_cnt  <= '0;
            r_tick <= enable;
            r_clk  <= enable && (r_pval > WIDTH'(1));
         end else if (enable) begin
            r_cnt  <= w_cnt_next;
            r_tick <= w_wrap;
            r_clk  <= (w_d != WIDTH'(1)) && ({1'b0, w_cnt_next} < w_h);
         end else begin
            r_tick <= 1'b0;
         end
      end
   end
   assign div_ack    = r_ack;
   assign div_active = r_div;
   assign tick       = r_tick;
   assign clk_out    = r_clk;
endmodule
